// File: rtl/axi_add2_pkg.sv
// axi_add2_pkg: register index map, AXI response codes and small decode helpers
// shared by the axi_add2 AXI4-Lite responder and its register file.
`default_nettype none

package axi_add2_pkg;

  typedef logic [2:0] reg_idx_t;

  localparam reg_idx_t ADDR_OP_A     = 3'd0;
  localparam reg_idx_t ADDR_OP_B     = 3'd1;
  localparam reg_idx_t ADDR_SCRATCH0 = 3'd2;
  localparam reg_idx_t ADDR_SCRATCH1 = 3'd3;
  localparam reg_idx_t ADDR_SUM      = 3'd4;
  localparam reg_idx_t ADDR_STATUS   = 3'd5;

  localparam int       NUM_RW_REGS = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Writable registers occupy indices 0..3, so bit 2 alone separates them.
  function automatic logic is_rw(input reg_idx_t idx);
    return ~idx[2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_add2_lite_if.sv
// axi_add2_lite_if: AXI4-Lite bus bundle (32-bit data) with master and slave views.
`default_nettype none

interface axi_add2_lite_if #(
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

`default_nettype wire

// File: rtl/axi_add2_regfile.sv
// axi_add2_regfile: four byte-writable registers, op_a+op_b adder with carry,
// and the combinational read mux for the axi_add2 register map.
`default_nettype none

module axi_add2_regfile
  import axi_add2_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        i_wr_en,
  input  wire reg_idx_t    i_wr_idx,
  input  wire logic [31:0] i_wr_data,
  input  wire logic [3:0]  i_wr_strb,
  input  wire reg_idx_t    i_rd_idx,
  output logic [31:0]      o_rd_data,
  output logic             o_rd_err,
  output logic             o_wr_err
);

  logic [31:0] r_regs [NUM_RW_REGS];
  logic [32:0] w_sum;
  logic        w_wr_ok;

  assign w_sum    = {1'b0, r_regs[ADDR_OP_A[1:0]]} + {1'b0, r_regs[ADDR_OP_B[1:0]]};
  assign w_wr_ok  = i_wr_en & is_rw(i_wr_idx);
  assign o_wr_err = ~is_rw(i_wr_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RW_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wr_strb[b]) begin
          r_regs[i_wr_idx[1:0]][8*b +: 8] <= i_wr_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    o_rd_err  = 1'b0;
    case (i_rd_idx)
      ADDR_OP_A, ADDR_OP_B, ADDR_SCRATCH0, ADDR_SCRATCH1:
                  o_rd_data = r_regs[i_rd_idx[1:0]];
      ADDR_SUM:    o_rd_data = w_sum[31:0];
      ADDR_STATUS: o_rd_data = {31'b0, w_sum[32]};
      default:     o_rd_err  = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/axi_add2_lite_slave.sv
// axi_add2_lite_slave: AXI4-Lite responder for the axi_add2 peripheral; one
// outstanding write and one outstanding read, independent AW/W acceptance.
`default_nettype none

module axi_add2_lite_slave
  import axi_add2_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
)(
  input  wire logic        ACLK,
  input  wire logic        ARESET,
  axi_add2_lite_if.slave   s_axi
);

  if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_width
    $error("axi_add2_lite_slave: only 32-bit data width is supported");
  end

  logic        r_aw_hold;
  logic        r_w_hold;
  reg_idx_t    r_aw_idx;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic        r_rvalid;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;

  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_ar_hs;
  logic        w_commit;
  reg_idx_t    w_wr_idx;
  logic [31:0] w_wr_data;
  logic [3:0]  w_wr_strb;
  logic [31:0] w_rd_data;
  logic        w_rd_err;
  logic        w_wr_err;
  logic        w_unused;

  assign s_axi.awready = ~r_aw_hold & ~r_bvalid;
  assign s_axi.wready  = ~r_w_hold & ~r_bvalid;
  assign s_axi.arready = ~r_rvalid;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.rdata   = r_rdata;

  assign w_aw_hs = s_axi.awvalid & s_axi.awready;
  assign w_w_hs  = s_axi.wvalid & s_axi.wready;
  assign w_ar_hs = s_axi.arvalid & s_axi.arready;

  // A held half and a half handshaking this cycle combine into one commit.
  assign w_commit  = (r_aw_hold | w_aw_hs) & (r_w_hold | w_w_hs);
  assign w_wr_idx  = r_aw_hold ? r_aw_idx : reg_idx_t'(s_axi.awaddr[4:2]);
  assign w_wr_data = r_w_hold ? r_wdata : s_axi.wdata;
  assign w_wr_strb = r_w_hold ? r_wstrb : s_axi.wstrb;

  assign w_unused = &{1'b0, s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  axi_add2_regfile u_regfile (
    .clk       (ACLK),
    .rst       (ARESET),
    .i_wr_en   (w_commit),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (w_wr_data),
    .i_wr_strb (w_wr_strb),
    .i_rd_idx  (reg_idx_t'(s_axi.araddr[4:2])),
    .o_rd_data (w_rd_data),
    .o_rd_err  (w_rd_err),
    .o_wr_err  (w_wr_err)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_aw_hold <= 1'b0;
      r_w_hold  <= 1'b0;
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_aw_hold <= 1'b1;
        r_aw_idx  <= reg_idx_t'(s_axi.awaddr[4:2]);
      end
      if (w_w_hs) begin
        r_w_hold <= 1'b1;
        r_wdata  <= s_axi.wdata;
        r_wstrb  <= s_axi.wstrb;
      end
      if (w_commit) begin
        r_aw_hold <= 1'b0;
        r_w_hold  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_bvalid && s_axi.bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
      r_rdata  <= w_rd_data;
    end else if (r_rvalid && s_axi.rready) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_add2_lite_slave.sv
// tb_axi_add2_lite_slave: directed, self-checking bench for the axi_add2 AXI4-Lite responder.
`default_nettype none

module tb_axi_add2_lite_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  axi_add2_lite_if #(.ADDR_WIDTH(5)) bus ();

  axi_add2_lite_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (5)
  ) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .s_axi  (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
  endtask

  // AW and W presented together; waits (bounded) for both handshakes and the B response.
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, got_b = 0;
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    resp = 2'bxx;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      bit a = bus.awready, w = bus.wready;
      step();
      if (a) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (w) begin w_done = 1; bus.wvalid = 1'b0; end
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    for (int i = 0; i < 20 && !got_b; i++) begin
      if (bus.bvalid) begin resp = bus.bresp; got_b = 1; end
      step();
    end
    bus.bready = 1'b0;
    n_cmp++;
    if (!got_b) begin
      n_err++;
      $display("FAIL write_timeout addr=%h: got no B response, required one within 20 cycles", addr);
    end
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ar_done = 0, got_r = 0;
    bus.araddr = addr; bus.arvalid = 1'b1;
    data = 'x; resp = 2'bxx;
    for (int i = 0; i < 20 && !ar_done; i++) begin
      bit a = bus.arready;
      step();
      if (a) ar_done = 1;
    end
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    for (int i = 0; i < 20 && !got_r; i++) begin
      if (bus.rvalid) begin data = bus.rdata; resp = bus.rresp; got_r = 1; end
      step();
    end
    bus.rready = 1'b0;
    n_cmp++;
    if (!got_r) begin
      n_err++;
      $display("FAIL read_timeout addr=%h: got no R response, required one within 20 cycles", addr);
    end
  endtask

  task automatic test_reset();
    idle_bus();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    n_cmp++; if (bus.awready !== 1'b1) begin n_err++; $display("FAIL reset_awready got=%b want=1", bus.awready); end
    n_cmp++; if (bus.wready !== 1'b1) begin n_err++; $display("FAIL reset_wready got=%b want=1", bus.wready); end
    n_cmp++; if (bus.arready !== 1'b1) begin n_err++; $display("FAIL reset_arready got=%b want=1", bus.arready); end
    n_cmp++; if (bus.bvalid !== 1'b0) begin n_err++; $display("FAIL reset_bvalid got=%b want=0", bus.bvalid); end
    n_cmp++; if (bus.rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got=%b want=0", bus.rvalid); end
    n_cmp++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got=%h want=0", bus.rdata); end
    n_cmp++; if (bus.bresp !== 2'b00 || bus.rresp !== 2'b00) begin
      n_err++; $display("FAIL reset_resp got b=%b r=%b want 00/00", bus.bresp, bus.rresp);
    end
  endtask

  task automatic test_basic_rw();
    logic [1:0]  resp;
    logic [31:0] data;
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, resp);
      n_cmp++; if (resp !== 2'b00) begin n_err++; $display("FAIL basic_bresp[%0d] got=%b want=00", i, resp); end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), data, resp);
      n_cmp++; if (data !== 32'(i + 1) || resp !== 2'b00) begin
        n_err++; $display("FAIL basic_read[%0d] got=%h/%b want=%h/00", i, data, resp, i + 1);
      end
    end
  endtask

  task automatic test_sum_carry();
    logic [1:0]  resp;
    logic [31:0] data;
    axi_write(5'h00, 32'hFFFF_FFFF, 4'hF, resp);
    axi_write(5'h04, 32'h0000_0002, 4'hF, resp);
    axi_read(5'h10, data, resp);
    n_cmp++; if (data !== 32'h1 || resp !== 2'b00) begin n_err++; $display("FAIL sum_wrap got=%h/%b want=00000001/00", data, resp); end
    axi_read(5'h14, data, resp);
    n_cmp++; if (data !== 32'h1) begin n_err++; $display("FAIL carry_set got=%h want=00000001", data); end
    axi_write(5'h00, 32'h0000_0003, 4'hF, resp);
    axi_read(5'h17, data, resp);
    n_cmp++; if (data !== 32'h0) begin n_err++; $display("FAIL carry_clear got=%h want=00000000", data); end
    axi_read(5'h10, data, resp);
    n_cmp++; if (data !== 32'h5) begin n_err++; $display("FAIL sum_small got=%h want=00000005", data); end
  endtask

  // Read of op_b in the same cycle as a write commit to op_b must see the old value.
  task automatic test_read_during_commit();
    logic [1:0]  resp;
    logic [31:0] data;
    bus.awaddr = 5'h04; bus.awvalid = 1'b1;
    bus.wdata = 32'h9; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = 5'h04; bus.arvalid = 1'b1;
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    n_cmp++; if (bus.bvalid !== 1'b1 || bus.rvalid !== 1'b1) begin
      n_err++; $display("FAIL concurrent_valids got b=%b r=%b want 1/1", bus.bvalid, bus.rvalid);
    end
    n_cmp++; if (bus.rdata !== 32'h2) begin n_err++; $display("FAIL concurrent_old_value got=%h want=00000002", bus.rdata); end
    bus.bready = 1'b1; bus.rready = 1'b1;
    step();
    bus.bready = 1'b0; bus.rready = 1'b0;
    axi_read(5'h04, data, resp);
    n_cmp++; if (data !== 32'h9) begin n_err++; $display("FAIL concurrent_new_value got=%h want=00000009", data); end
  endtask

  task automatic test_strobe();
    logic [1:0]  resp;
    logic [31:0] data;
    axi_write(5'h00, 32'h1122_3344, 4'hF, resp);
    axi_write(5'h01, 32'hAABB_CCDD, 4'b0010, resp);
    axi_read(5'h00, data, resp);
    n_cmp++; if (data !== 32'h1122_CC44) begin n_err++; $display("FAIL strobe_byte1 got=%h want=1122cc44", data); end
    axi_write(5'h00, 32'hFFFF_FFFF, 4'b0000, resp);
    n_cmp++; if (resp !== 2'b00) begin n_err++; $display("FAIL strobe_zero_bresp got=%b want=00", resp); end
    axi_read(5'h00, data, resp);
    n_cmp++; if (data !== 32'h1122_CC44) begin n_err++; $display("FAIL strobe_zero_nochange got=%h want=1122cc44", data); end
  endtask

  task automatic test_slverr();
    logic [1:0]  resp;
    logic [31:0] data;
    axi_write(5'h10, 32'hDEAD_BEEF, 4'hF, resp);
    n_cmp++; if (resp !== 2'b10) begin n_err++; $display("FAIL wr_sum_slverr got=%b want=10", resp); end
    axi_read(5'h10, data, resp);
    n_cmp++; if (data !== 32'h1122_CC4D || resp !== 2'b00) begin
      n_err++; $display("FAIL sum_unchanged got=%h/%b want=1122cc4d/00", data, resp);
    end
    axi_write(5'h1C, 32'h1234_5678, 4'hF, resp);
    n_cmp++; if (resp !== 2'b10) begin n_err++; $display("FAIL wr_unmapped_slverr got=%b want=10", resp); end
    axi_read(5'h18, data, resp);
    n_cmp++; if (data !== 32'h0 || resp !== 2'b10) begin
      n_err++; $display("FAIL rd_unmapped got=%h/%b want=00000000/10", data, resp);
    end
  endtask

  task automatic test_write_order();
    logic [1:0]  resp;
    logic [31:0] data;
    // Address three cycles ahead of data
    bus.awaddr = 5'h08; bus.awvalid = 1'b1;
    step();
    bus.awvalid = 1'b0;
    n_cmp++; if (bus.awready !== 1'b0 || bus.wready !== 1'b1) begin
      n_err++; $display("FAIL aw_first_readies got aw=%b w=%b want 0/1", bus.awready, bus.wready);
    end
    repeat (3) step();
    n_cmp++; if (bus.bvalid !== 1'b0) begin n_err++; $display("FAIL aw_first_early_b got=%b want=0", bus.bvalid); end
    bus.wdata = 32'hA5A5_A5A5; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    step();
    bus.wvalid = 1'b0;
    n_cmp++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
      n_err++; $display("FAIL aw_first_b got=%b/%b want 1/00", bus.bvalid, bus.bresp);
    end
    bus.bready = 1'b1; step(); bus.bready = 1'b0;
    step();
    n_cmp++; if (bus.bvalid !== 1'b0) begin n_err++; $display("FAIL aw_first_single_b got=%b want=0", bus.bvalid); end
    // Data three cycles ahead of address
    bus.wdata = 32'h5A5A_5A5A; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    step();
    bus.wvalid = 1'b0;
    n_cmp++; if (bus.wready !== 1'b0 || bus.awready !== 1'b1) begin
      n_err++; $display("FAIL w_first_readies got aw=%b w=%b want 1/0", bus.awready, bus.wready);
    end
    repeat (3) step();
    n_cmp++; if (bus.bvalid !== 1'b0) begin n_err++; $display("FAIL w_first_early_b got=%b want=0", bus.bvalid); end
    bus.awaddr = 5'h0C; bus.awvalid = 1'b1;
    step();
    bus.awvalid = 1'b0;
    n_cmp++; if (bus.bvalid !== 1'b1) begin n_err++; $display("FAIL w_first_b got=%b want=1", bus.bvalid); end
    bus.bready = 1'b1; step(); bus.bready = 1'b0;
    step();
    n_cmp++; if (bus.bvalid !== 1'b0) begin n_err++; $display("FAIL w_first_single_b got=%b want=0", bus.bvalid); end
    axi_read(5'h08, data, resp);
    n_cmp++; if (data !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL aw_first_data got=%h want=a5a5a5a5", data); end
    axi_read(5'h0C, data, resp);
    n_cmp++; if (data !== 32'h5A5A_5A5A) begin n_err++; $display("FAIL w_first_data got=%h want=5a5a5a5a", data); end
  endtask

  task automatic test_b_stall_and_reset();
    logic [1:0]  resp;
    logic [31:0] data;
    bit          stable = 1;
    bus.awaddr = 5'h10; bus.awvalid = 1'b1;
    bus.wdata = 32'h1; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b10 || bus.awready !== 1'b0 || bus.wready !== 1'b0) stable = 0;
      step();
    end
    n_cmp++; if (!stable) begin n_err++; $display("FAIL b_stall_stable got unstable B/readies want bvalid=1 bresp=10 ready=0"); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.bvalid !== 1'b0) begin n_err++; $display("FAIL reset_mid_b got=%b want=0", bus.bvalid); end
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      axi_read(5'(i * 4), data, resp);
      n_cmp++; if (data !== 32'h0) begin n_err++; $display("FAIL post_reset_read[%0d] got=%h want=00000000", i, data); end
    end
  endtask

  initial begin
    idle_bus();
    test_reset();
    test_basic_rw();
    test_sum_carry();
    test_read_during_commit();
    test_strobe();
    test_slverr();
    test_write_order();
    test_b_stall_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
